ghash_pipe_ctrl: RTL and testbench

Sequencing controller for the three-register GHASH core pipeline. It accepts one message of N_BLOCKS-wide data beats and drives the per-stage valid enables. It clears the feedback path on the first beat and injects the GCM length block after the last beat. It pulses a tag-valid strobe when the final accumulated product leaves the last pipe stage, and flags beat-count mismatches against the declared lengths.

---
 rtl/ghash_pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_ghash_pipe_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghash_pipe_ctrl.sv
// Sequencing controller for a registered GHASH core pipeline: stage enables,
// feedback clear, length-block injection, tag strobe and beat-count checking.
module ghash_pipe_ctrl #(
    parameter int NB_BLOCK   = 128,
    parameter int N_BLOCKS   = 2,
    parameter int NB_DATA    = N_BLOCKS * NB_BLOCK,
    parameter int PIPE_DEPTH = 3,
    parameter int NB_LEN     = 64,
    parameter int NB_CNT     = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_sop,
    input  logic                  i_eop,
    input  logic [NB_LEN-1:0]     i_aad_len,
    input  logic [NB_LEN-1:0]     i_data_len,
    output logic                  o_ready,
    output logic [PIPE_DEPTH-1:0] o_stage_valid,
    output logic                  o_feedback_clear,
    output logic                  o_len_insert,
    output logic [NB_BLOCK-1:0]   o_len_block,
    output logic                  o_tag_valid,
    output logic                  o_len_error,
    output logic                  o_busy
);

    localparam int LG_BLOCK = $clog2(NB_BLOCK);
    localparam int LG_NBLK  = $clog2(N_BLOCKS);
    localparam int DW       = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, DATA, LEN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [PIPE_DEPTH-1:1] tok_q, tok_d;
    logic [NB_LEN-1:0]     aad_q, aad_d;
    logic [NB_LEN-1:0]     dlen_q, dlen_d;
    logic [NB_CNT-1:0]     beat_cnt_q, beat_cnt_d;
    logic [NB_CNT-1:0]     exp_q, exp_d;
    logic [DW-1:0]         drain_cnt_q, drain_cnt_d;
    logic                  err_q, err_d;

    logic                  run;
    logic                  accept;
    logic                  sop_acc;
    logic                  issue;
    logic [PIPE_DEPTH-1:0] sv_all;
    logic [NB_CNT-1:0]     blocks;
    logic [NB_CNT-1:0]     bsum;
    logic [NB_CNT-1:0]     exp_calc;

    function automatic logic [NB_CNT-1:0] ceil_blk(input logic [NB_LEN-1:0] len);
        logic [NB_LEN:0] s;
        s = {1'b0, len} + (NB_LEN+1)'(NB_BLOCK - 1);
        return NB_CNT'(s >> LG_BLOCK);
    endfunction

    always_comb begin
        run              = ~i_reset;
        o_ready          = run & ((state_q == IDLE) | (state_q == DATA));
        accept           = i_valid & o_ready & ((state_q == IDLE) ? i_sop : 1'b1);
        sop_acc          = accept & (state_q == IDLE);
        issue            = accept | (run & (state_q == LEN));
        sv_all           = {tok_q, issue};
        o_stage_valid    = sv_all;
        o_feedback_clear = sop_acc;
        o_len_insert     = run & (state_q == LEN);
        o_tag_valid      = run & (state_q == DRAIN) & (drain_cnt_q == '0);
        o_len_block      = NB_BLOCK'({aad_q, dlen_q});
        o_len_error      = err_q;
        o_busy           = (state_q != IDLE);

        blocks   = ceil_blk(i_aad_len) + ceil_blk(i_data_len);
        bsum     = blocks + NB_CNT'(N_BLOCKS - 1);
        exp_calc = bsum >> LG_NBLK;
        if (exp_calc == '0) exp_calc = NB_CNT'(1);
    end

    always_comb begin
        state_d     = state_q;
        tok_d       = sv_all[PIPE_DEPTH-2:0];
        aad_d       = aad_q;
        dlen_d      = dlen_q;
        beat_cnt_d  = beat_cnt_q;
        exp_d       = exp_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (sop_acc) begin
                    aad_d      = i_aad_len;
                    dlen_d     = i_data_len;
                    beat_cnt_d = NB_CNT'(1);
                    exp_d      = exp_calc;
                    err_d      = 1'b0;
                    state_d    = i_eop ? LEN : DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + NB_CNT'(1);
                    if (i_eop) state_d = LEN;
                end
            end
            LEN: begin
                // The LEN cycle sees the final count; DATA never updates it after EOP.
                err_d       = err_q | (beat_cnt_q != exp_q);
                drain_cnt_d = DW'(PIPE_DEPTH - 1);
                state_d     = DRAIN;
            end
            default: begin
                if (drain_cnt_q == '0) state_d = IDLE;
                else drain_cnt_d = drain_cnt_q - DW'(1);
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= IDLE;
            tok_q       <= '0;
            aad_q       <= '0;
            dlen_q      <= '0;
            beat_cnt_q  <= '0;
            exp_q       <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tok_q       <= tok_d;
            aad_q       <= aad_d;
            dlen_q      <= dlen_d;
            beat_cnt_q  <= beat_cnt_d;
            exp_q       <= exp_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ghash_pipe_ctrl.sv
// Randomized and directed bench for ghash_pipe_ctrl against a message-level
// timing model (issue times, LEN slot, tag slot, expected beat count).
module tb_ghash_pipe_ctrl;

    localparam int P   = 3;
    localparam int NBB = 128;
    localparam int NB  = 2;
    localparam int NBL = 64;
    localparam int NBC = 32;
    localparam int LN  = 8192;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_valid, i_sop, i_eop;
    logic [NBL-1:0] i_aad_len, i_data_len;
    logic           o_ready, o_feedback_clear, o_len_insert;
    logic           o_tag_valid, o_len_error, o_busy;
    logic [P-1:0]   o_stage_valid;
    logic [NBB-1:0] o_len_block;

    ghash_pipe_ctrl #(
        .NB_BLOCK(NBB), .N_BLOCKS(NB), .NB_DATA(NB*NBB),
        .PIPE_DEPTH(P), .NB_LEN(NBL), .NB_CNT(NBC)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_valid(i_valid),
        .i_sop(i_sop), .i_eop(i_eop),
        .i_aad_len(i_aad_len), .i_data_len(i_data_len),
        .o_ready(o_ready), .o_stage_valid(o_stage_valid),
        .o_feedback_clear(o_feedback_clear), .o_len_insert(o_len_insert),
        .o_len_block(o_len_block), .o_tag_valid(o_tag_valid),
        .o_len_error(o_len_error), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [P-1:0]   lg_sv  [LN];
    logic [NBB-1:0] lg_lb  [LN];
    logic           lg_tag [LN];
    logic           lg_fbc [LN];
    logic           lg_lin [LN];
    logic           lg_rdy [LN];
    logic           lg_err [LN];
    logic           lg_bsy [LN];

    always @(negedge clk) begin
        lg_sv[cyc % LN]  = o_stage_valid;
        lg_lb[cyc % LN]  = o_len_block;
        lg_tag[cyc % LN] = o_tag_valid;
        lg_fbc[cyc % LN] = o_feedback_clear;
        lg_lin[cyc % LN] = o_len_insert;
        lg_rdy[cyc % LN] = o_ready;
        lg_err[cyc % LN] = o_len_error;
        lg_bsy[cyc % LN] = o_busy;
    end

    int   n_chk = 0;
    int   n_fail = 0;
    logic prev_err = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_beats(input longint unsigned a, input longint unsigned d);
        longint unsigned b, e;
        b = (a + NBB - 1) / NBB + (d + NBB - 1) / NBB;
        e = (b + NB - 1) / NB;
        return (e == 0) ? 1 : int'(e);
    endfunction

    // Drives one message: beats on the set bits of vpat (bit 0 must be set).
    // noise=1 puts SOP on every data beat and offers beats while draining.
    task automatic run_msg(input logic [63:0] aad, input logic [63:0] dl,
                           input logic [63:0] vpat, input bit noise);
        int            n, idx, a0, L, rel;
        int            acc[$];
        logic [127:0]  iss;
        logic [P-1:0]  esv;
        logic          mism;
        logic          e_err;
        n   = $countones(vpat);
        idx = 0;
        for (int b = 0; b < 64 && idx < n; b++) begin
            if (vpat[b]) begin
                i_valid    = 1'b1;
                i_sop      = (idx == 0) ? 1'b1 : noise;
                i_eop      = (idx == n - 1);
                i_aad_len  = (idx == 0) ? aad : {$urandom, $urandom};
                i_data_len = (idx == 0) ? dl : {$urandom, $urandom};
                acc.push_back(cyc);
                idx++;
            end else begin
                i_valid    = 1'b0;
                i_sop      = 1'($urandom_range(0, 1));
                i_eop      = 1'($urandom_range(0, 1));
                i_aad_len  = {$urandom, $urandom};
                i_data_len = {$urandom, $urandom};
            end
            step();
        end
        a0 = acc[0];
        L  = acc[n-1] + 1;
        for (int c = 0; c <= P; c++) begin
            i_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            i_sop   = 1'($urandom_range(0, 1));
            i_eop   = 1'($urandom_range(0, 1));
            step();
        end
        i_valid = 1'b0;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
        step();
        iss = '0;
        foreach (acc[i]) iss[acc[i]-a0] = 1'b1;
        iss[L-a0] = 1'b1;
        mism = (n != exp_beats(aad, dl));
        for (int c = a0; c <= L + P + 1; c++) begin
            for (int k = 0; k < P; k++) begin
                rel    = c - k - a0;
                esv[k] = (rel >= 0) ? iss[rel] : 1'b0;
            end
            n_chk++;
            if (lg_sv[c%LN] !== esv) begin
                n_fail++;
                $display("FAIL stage_valid cyc=%0d got=%b exp=%b", c - a0, lg_sv[c%LN], esv);
            end
            n_chk++;
            if (lg_fbc[c%LN] !== (c == a0)) begin
                n_fail++;
                $display("FAIL feedback_clear cyc=%0d got=%b exp=%b", c - a0, lg_fbc[c%LN], c == a0);
            end
            n_chk++;
            if (lg_lin[c%LN] !== (c == L)) begin
                n_fail++;
                $display("FAIL len_insert cyc=%0d got=%b exp=%b", c - a0, lg_lin[c%LN], c == L);
            end
            n_chk++;
            if (lg_tag[c%LN] !== (c == L + P)) begin
                n_fail++;
                $display("FAIL tag_valid cyc=%0d got=%b exp=%b", c - a0, lg_tag[c%LN], c == L + P);
            end
            n_chk++;
            if (lg_rdy[c%LN] !== (c < L || c == L + P + 1)) begin
                n_fail++;
                $display("FAIL ready cyc=%0d got=%b exp=%b", c - a0, lg_rdy[c%LN], (c < L || c == L + P + 1));
            end
            n_chk++;
            if (lg_bsy[c%LN] !== (c > a0 && c <= L + P)) begin
                n_fail++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", c - a0, lg_bsy[c%LN], (c > a0 && c <= L + P));
            end
            e_err = (c == a0) ? prev_err : ((c <= L) ? 1'b0 : mism);
            n_chk++;
            if (lg_err[c%LN] !== e_err) begin
                n_fail++;
                $display("FAIL len_error cyc=%0d got=%b exp=%b", c - a0, lg_err[c%LN], e_err);
            end
            if (c == L || c == L + P + 1) begin
                n_chk++;
                if (lg_lb[c%LN] !== {aad, dl}) begin
                    n_fail++;
                    $display("FAIL len_block cyc=%0d got=%h exp=%h", c - a0, lg_lb[c%LN], {aad, dl});
                end
            end
        end
        prev_err = mism;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        n_chk++;
        if ({o_stage_valid, o_feedback_clear, o_len_insert, o_tag_valid,
             o_len_error, o_busy, o_ready} !== '0 || o_len_block !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs sv=%b tag=%b rdy=%b busy=%b", o_stage_valid, o_tag_valid, o_ready, o_busy);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got=%b exp=1", o_ready);
        end
        step();
        prev_err = 1'b0;
    endtask

    task automatic test_single_beat();
        run_msg(64'd0, 64'd256, 64'h1, 1'b0);
        run_msg(64'd0, 64'd0, 64'h1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_msg(64'd128, 64'd896, 64'hF, 1'b0);
        run_msg(64'd100, 64'd1000, 64'h1F, 1'b0);
    endtask

    task automatic test_len_mismatch();
        run_msg(64'd128, 64'd896, 64'h7, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if (o_len_error !== 1'b1) begin
                n_fail++;
                $display("FAIL err_held got=%b exp=1", o_len_error);
            end
            step();
        end
        run_msg(64'd0, 64'd256, 64'h1, 1'b0);
    endtask

    task automatic test_gapped();
        run_msg(64'd128, 64'd512, 64'b100101, 1'b0);
    endtask

    task automatic test_idle_nonsop_data_sop();
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            i_sop   = 1'b0;
            i_eop   = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_chk++;
            if (o_stage_valid !== '0 || o_feedback_clear !== 1'b0 || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_nonsop sv=%b fbc=%b busy=%b exp=0", o_stage_valid, o_feedback_clear, o_busy);
            end
            step();
        end
        i_valid = 1'b0;
        i_eop   = 1'b0;
        step();
        run_msg(64'd128, 64'd384, 64'h3, 1'b1);
        run_msg(64'd256, 64'd256, 64'b1011, 1'b1);
    endtask

    task automatic test_reset_in_drain();
        int L;
        i_valid    = 1'b1;
        i_sop      = 1'b1;
        i_eop      = 1'b1;
        i_aad_len  = 64'd0;
        i_data_len = 64'd256;
        step();
        i_valid = 1'b0;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
        L       = cyc;
        step();
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        n_chk++;
        if ({o_stage_valid, o_feedback_clear, o_len_insert, o_tag_valid,
             o_len_error, o_busy, o_ready} !== '0 || o_len_block !== '0) begin
            n_fail++;
            $display("FAIL drain_reset_outputs sv=%b tag=%b rdy=%b busy=%b", o_stage_valid, o_tag_valid, o_ready, o_busy);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (o_ready !== 1'b1 || o_stage_valid !== '0) begin
            n_fail++;
            $display("FAIL drain_reset_release rdy=%b sv=%b exp rdy=1 sv=0", o_ready, o_stage_valid);
        end
        step();
        step();
        step();
        for (int c = L + 1; c <= L + P + 2; c++) begin
            n_chk++;
            if (lg_tag[c%LN] !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_reset_tag cyc=%0d got=%b exp=0", c - L, lg_tag[c%LN]);
            end
        end
        prev_err = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] a, d, pat;
        int          n, pos;
        for (int t = 0; t < 30; t++) begin
            a = 64'($urandom_range(0, 1100));
            d = 64'($urandom_range(0, 1100));
            if ($urandom_range(0, 7) == 0) a = 64'd0;
            n = exp_beats(a, d) + $urandom_range(0, 2) - 1;
            if (n < 1) n = 1;
            pat = '0;
            pos = 0;
            for (int i = 0; i < n; i++) begin
                pat[pos] = 1'b1;
                pos += 1 + $urandom_range(0, 2);
            end
            run_msg(a, d, pat, 1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
    endtask

    initial begin
        rst        = 1'b1;
        i_valid    = 1'b0;
        i_sop      = 1'b0;
        i_eop      = 1'b0;
        i_aad_len  = '0;
        i_data_len = '0;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_len_mismatch();
        test_gapped();
        test_idle_nonsop_data_sop();
        test_reset_in_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
